// File: rtl/mult_pkg.sv
// +------------------------------------------------------------------+
// | mult_pkg : shared widths and state encoding for the MAC datapath |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

    localparam int PROD_W = 8;
    localparam int OP_W   = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_acc_add.sv
// +------------------------------------------------------------------+
// | mult_acc_add : ACC_W accumulate adder with carry out; clamps to  |
// |                all-ones on carry when MULT_ACC_SATURATE_EN set   |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
`default_nettype none

module mult_acc_add
    import mult_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] raw_sum;

    always_comb begin
        raw_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
        carry   = raw_sum[ACC_W];
`ifdef MULT_ACC_SATURATE_EN
        // Once clamped, any further nonzero add carries again, so it stays pinned.
        sum     = carry ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
`else
        sum     = raw_sum[ACC_W-1:0];
`endif
    end

endmodule

`default_nettype wire

// File: rtl/mult_accumulator.sv
// +------------------------------------------------------------------+
// | mult_accumulator : sums a frame of products, presents total,     |
// |   beat count and sticky overflow on a held output handshake.     |
// |   Option macro: MULT_ACC_SATURATE_EN (clamp instead of wrap).    |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
`default_nettype none

module mult_accumulator
    import mult_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  out_count,
    output logic              overflow
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   acc_out_q, acc_out_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               overflow_q, overflow_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic [CNT_W-1:0]   cnt_inc;
    logic               beat;
    logic               out_hs;

    mult_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc    (acc_q),
        .addend (product),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        acc_out_d   = acc_out_q;
        out_count_d = out_count_q;
        overflow_d  = overflow_q;

        // in_ready_q is only high in ACCUM, so it alone qualifies a beat.
        beat    = in_valid && in_ready_q;
        out_hs  = out_valid_q && out_ready;
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            ACCUM: begin
                if (beat) begin
                    if (in_last) begin
                        acc_out_d   = add_sum;
                        out_count_d = cnt_inc;
                        overflow_d  = ovf_q | add_carry;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = add_sum;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | add_carry;
                    end
                end
            end
            HOLD: begin
                if (out_hs) begin
                    overflow_d = 1'b0;
                    state_d    = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase

        if (clr) begin
            state_d     = ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            acc_out_d   = '0;
            out_count_d = '0;
            overflow_d  = 1'b0;
        end

        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            acc_out_q   <= '0;
            out_count_q <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            acc_out_q   <= acc_out_d;
            out_count_q <= out_count_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign out_count = out_count_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire
